// File: rtl/v_rr_dispatcher_if.sv
// Decoder-to-dispatcher bundle for v_rr_dispatcher.
//   master : decoder / slot side (drives instruction fields and slot status)
//   slave  : dispatcher (drives ack, start pulses, load occupancy, turn, fenced)
// Signals:
//   req, stall, is_vload, is_vstore, is_vcfg, is_serial : decoded instruction
//   alu_compat[ALU_SLOTS], slot_active[ALU_SLOTS]      : ALU slot info
//   ld_end[LD_SLOTS], vcfg_done                         : completion events
//   ack[ACK_FANOUT], slot_init, ld_slot_init, ld_slot_valid, turn, fenced
interface v_rr_dispatcher_if #(
  parameter int ALU_SLOTS  = 4,
  parameter int LD_SLOTS   = 2,
  parameter int ACK_FANOUT = 9
);
  localparam int TW = $clog2(ALU_SLOTS);

  logic                  req;
  logic                  stall;
  logic                  is_vload;
  logic                  is_vstore;
  logic                  is_vcfg;
  logic                  is_serial;
  logic [ALU_SLOTS-1:0]  alu_compat;
  logic [ALU_SLOTS-1:0]  slot_active;
  logic [LD_SLOTS-1:0]   ld_end;
  logic                  vcfg_done;

  logic [ACK_FANOUT-1:0] ack;
  logic [ALU_SLOTS-1:0]  slot_init;
  logic [LD_SLOTS-1:0]   ld_slot_init;
  logic [LD_SLOTS-1:0]   ld_slot_valid;
  logic [TW-1:0]         turn;
  logic                  fenced;

  modport master (
    output req, stall, is_vload, is_vstore, is_vcfg, is_serial,
    output alu_compat, slot_active, ld_end, vcfg_done,
    input  ack, slot_init, ld_slot_init, ld_slot_valid, turn, fenced
  );

  modport slave (
    input  req, stall, is_vload, is_vstore, is_vcfg, is_serial,
    input  alu_compat, slot_active, ld_end, vcfg_done,
    output ack, slot_init, ld_slot_init, ld_slot_valid, turn, fenced
  );
endinterface

// File: rtl/v_rr_dispatcher.sv
// Vector instruction dispatcher: issues decoded instructions to ALU slots
// (round-robin from an internal turn pointer), load slots (lowest free) and
// the vcfg path, with a fence FSM that serialises vcfg/widen/narrow.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : v_rr_dispatcher_if.slave
//          in : req, stall, is_vload, is_vstore, is_vcfg, is_serial,
//               alu_compat, slot_active, ld_end, vcfg_done
//          out: ack (replicated), slot_init, ld_slot_init, ld_slot_valid,
//               turn, fenced
// Grant decision in cycle N shows up as a one-cycle ack + init pulse in N+1.
module v_rr_dispatcher #(
  parameter int ALU_SLOTS       = 4,
  parameter int LD_SLOTS        = 2,
  parameter int ACK_FANOUT      = 9,
  parameter int FENCE_MIN       = 8,
  parameter int ENABLE_STALLING = 1
) (
  input  logic              clk,
  input  logic              rst,
  v_rr_dispatcher_if.slave  bus
);

  localparam int          TW    = $clog2(ALU_SLOTS);
  localparam int          CW    = (FENCE_MIN > 0) ? $clog2(FENCE_MIN + 1) : 1;
  localparam int unsigned N_ALU = ALU_SLOTS;

  typedef enum logic [1:0] {
    ST_OPEN,
    ST_DRAIN,
    ST_HOLD
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [ACK_FANOUT-1:0] r_ack;
  logic [ALU_SLOTS-1:0]  r_slot_init;
  logic [LD_SLOTS-1:0]   r_ld_init;
  logic [LD_SLOTS-1:0]   r_ld_valid;
  logic [TW-1:0]         r_turn;
  logic [ALU_SLOTS-1:0]  r_store;

  logic                  w_stall;
  logic [ALU_SLOTS-1:0]  w_busy_alu;
  logic                  w_any_busy;
  logic                  w_q;
  logic                  w_open_ok;
  logic                  w_store_blk;
  logic                  w_alu_en;
  logic                  w_ld_en;
  logic [ALU_SLOTS-1:0]  w_cand;
  logic [ALU_SLOTS-1:0]  w_grant_alu;
  logic [LD_SLOTS-1:0]   w_ld_free;
  logic [LD_SLOTS-1:0]   w_grant_ld;
  logic [TW-1:0]         w_turn_nxt;
  logic                  w_ack_nxt;

  // First set bit of cand scanning start, start+1, ... modulo ALU_SLOTS.
  function automatic logic [ALU_SLOTS-1:0] rr_select(
    input logic [ALU_SLOTS-1:0] cand,
    input logic [TW-1:0]        start
  );
    logic [ALU_SLOTS-1:0] sel;
    logic                 found;
    int unsigned          idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < N_ALU; off++) begin
      idx = 32'(start) + off;
      if (idx >= N_ALU) idx = idx - N_ALU;
      if (!found && cand[idx[TW-1:0]]) begin
        sel[idx[TW-1:0]] = 1'b1;
        found            = 1'b1;
      end
    end
    return sel;
  endfunction

  assign w_stall    = (ENABLE_STALLING != 0) & bus.stall;
  // The registered init pulse covers the slot's own start latency.
  assign w_busy_alu = bus.slot_active | r_slot_init;
  assign w_any_busy = (|w_busy_alu) | (|r_ld_valid) | (|r_ld_init);
  // ~ack keeps a held instruction from being granted twice.
  assign w_q        = bus.req & ~r_ack[0] & ~w_stall;
  // Grants only from OPEN, and a serial instruction waits for an empty machine.
  assign w_open_ok  = (r_state == ST_OPEN) & ~(bus.is_serial & w_any_busy);
  assign w_store_blk = bus.is_vstore & (|r_store);

  assign w_alu_en = w_q & w_open_ok & ~bus.is_vload & ~bus.is_vcfg & ~w_store_blk;
  assign w_ld_en  = w_q & w_open_ok & bus.is_vload;

  assign w_cand      = bus.alu_compat & ~w_busy_alu;
  assign w_grant_alu = w_alu_en ? rr_select(w_cand, r_turn) : '0;

  // Lowest free load slot: isolate the least significant set bit.
  assign w_ld_free  = ~r_ld_valid;
  assign w_grant_ld = w_ld_en ? (w_ld_free & (~w_ld_free + 1'b1)) : '0;

  always_comb begin
    w_turn_nxt = r_turn;
    for (int unsigned k = 0; k < N_ALU; k++) begin
      if (w_grant_alu[k[TW-1:0]]) begin
        w_turn_nxt = (k == N_ALU - 1) ? '0 : TW'(k + 1);
      end
    end
  end

  assign w_ack_nxt = (|w_grant_alu) | (|w_grant_ld) | bus.vcfg_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_OPEN;
      r_cnt       <= '0;
      r_ack       <= '0;
      r_slot_init <= '0;
      r_ld_init   <= '0;
      r_ld_valid  <= '0;
      r_turn      <= '0;
      r_store     <= '0;
    end else begin
      r_ack       <= {ACK_FANOUT{w_ack_nxt}};
      r_slot_init <= w_grant_alu;
      r_ld_init   <= w_grant_ld;
      r_turn      <= w_turn_nxt;
      // Set beats end when both happen in the same cycle.
      r_ld_valid  <= r_ld_init | (r_ld_valid & ~bus.ld_end);
      r_store     <= (r_slot_init & {ALU_SLOTS{bus.is_vstore}})
                   | (~r_slot_init & r_store & bus.slot_active);

      case (r_state)
        ST_OPEN: begin
          // The decoder holds is_serial through the ack cycle, so ack with
          // is_serial identifies the acceptance of the serialising instruction.
          if (r_ack[0] && bus.is_serial) begin
            r_state <= ST_HOLD;
            r_cnt   <= CW'(FENCE_MIN);
          end else if (w_q && bus.is_serial && w_any_busy) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!w_any_busy) r_state <= ST_OPEN;
        end
        ST_HOLD: begin
          if (r_cnt == '0 && !w_any_busy) begin
            r_state <= ST_OPEN;
          end else if (r_cnt != '0 && !w_stall) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= ST_OPEN;
      endcase
    end
  end

  assign bus.ack           = r_ack;
  assign bus.slot_init     = r_slot_init;
  assign bus.ld_slot_init  = r_ld_init;
  assign bus.ld_slot_valid = r_ld_valid;
  assign bus.turn          = r_turn;
  assign bus.fenced        = (r_state != ST_OPEN);

endmodule

// File: tb/tb_v_rr_dispatcher.sv
// Directed bench for v_rr_dispatcher (ALU_SLOTS=4, LD_SLOTS=2, FENCE_MIN=8).
// A table of one-cycle vectors covers round-robin, load and store behaviour;
// hand sequences cover drain, hold length, stall during hold, vcfg and reset.
module tb_v_rr_dispatcher;

  localparam int FMIN = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  v_rr_dispatcher_if #(.ALU_SLOTS(4), .LD_SLOTS(2), .ACK_FANOUT(9)) bus ();

  v_rr_dispatcher #(
    .ALU_SLOTS(4), .LD_SLOTS(2), .ACK_FANOUT(9), .FENCE_MIN(FMIN), .ENABLE_STALLING(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // flags = {req, stall, is_vload, is_vstore, is_vcfg, is_serial}
  localparam logic [5:0] F_NONE = 6'b000000;
  localparam logic [5:0] F_ALU  = 6'b100000;
  localparam logic [5:0] F_STL  = 6'b110000;
  localparam logic [5:0] F_LD   = 6'b101000;
  localparam logic [5:0] F_ST   = 6'b100100;

  typedef struct {
    logic [5:0] flags;
    logic [3:0] compat;
    logic [3:0] act;
    logic [1:0] lend;
    logic       vd;
    logic       e_ack;
    logic [3:0] e_si;
    logic [1:0] e_li;
    logic [1:0] e_lv;
    logic [1:0] e_turn;
    logic       e_fen;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t V(input logic [5:0] f, input logic [3:0] cp, input logic [3:0] ac,
                             input logic [1:0] le, input logic vd, input logic ea,
                             input logic [3:0] esi, input logic [1:0] eli, input logic [1:0] elv,
                             input logic [1:0] etn, input logic ef);
    vec_t v;
    v.flags = f; v.compat = cp; v.act = ac; v.lend = le; v.vd = vd;
    v.e_ack = ea; v.e_si = esi; v.e_li = eli; v.e_lv = elv; v.e_turn = etn; v.e_fen = ef;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] f, input logic [3:0] cp, input logic [3:0] ac,
                       input logic [1:0] le, input logic vd);
    {bus.req, bus.stall, bus.is_vload, bus.is_vstore, bus.is_vcfg, bus.is_serial} = f;
    bus.alu_compat  = cp;
    bus.slot_active = ac;
    bus.ld_end      = le;
    bus.vcfg_done   = vd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ackv(input logic a);
    return a ? 32'h1FF : 32'h0;
  endfunction

  // Runs the HOLD window with the next (non-serial ALU) instruction waiting;
  // stall is raised for loop iterations [s0, s0+ns).
  task automatic hold_run(input string nm, input int s0, input int ns, input int exp_len,
                          input logic [3:0] exp_si);
    int  hold_len;
    int  ack_in_hold;
    bit  got_ack;
    hold_len    = 1;
    ack_in_hold = 0;
    got_ack     = 1'b0;
    for (int k = 0; k < 40 && !got_ack; k++) begin
      @(negedge clk);
      drive(F_ALU, 4'hF, 4'h0, 2'b00, 1'b0);
      bus.stall = (k >= s0 && k < s0 + ns);
      tick();
      if (bus.fenced) begin
        hold_len++;
        if (bus.ack[0]) ack_in_hold++;
      end else if (bus.ack[0]) begin
        got_ack = 1'b1;
      end
    end
    chk({nm, ".exit_ack"}, 32'(got_ack), 32'd1);
    chk({nm, ".hold_len"}, 32'(hold_len), 32'(exp_len));
    chk({nm, ".ack_in_hold"}, 32'(ack_in_hold), 32'd0);
    chk({nm, ".next_si"}, 32'(bus.slot_init), 32'(exp_si));
    // ack cycle keeps the instruction held, then the decoder goes idle
    @(negedge clk); drive(F_ALU, 4'hF, 4'h0, 2'b00, 1'b0); tick();
    @(negedge clk); drive(F_NONE, 4'h0, 4'h0, 2'b00, 1'b0); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit done;
    drive(F_NONE, 4'h0, 4'h0, 2'b00, 1'b0);

    //        flags   cmp   act   lend  vd   ack si     li     lv     turn  fen
    // round robin over idle slots from turn 0
    tbl.push_back(V(F_ALU, 4'hF, 4'h0, 2'b00, 0, 1, 4'b0001, 2'b00, 2'b00, 2'd1, 0)); // 0
    tbl.push_back(V(F_ALU, 4'hF, 4'h0, 2'b00, 0, 0, 4'b0000, 2'b00, 2'b00, 2'd1, 0));
    tbl.push_back(V(F_ALU, 4'hF, 4'h0, 2'b00, 0, 1, 4'b0010, 2'b00, 2'b00, 2'd2, 0));
    tbl.push_back(V(F_ALU, 4'hF, 4'h0, 2'b00, 0, 0, 4'b0000, 2'b00, 2'b00, 2'd2, 0));
    tbl.push_back(V(F_ALU, 4'hF, 4'h0, 2'b00, 0, 1, 4'b0100, 2'b00, 2'b00, 2'd3, 0));
    tbl.push_back(V(F_ALU, 4'hF, 4'h0, 2'b00, 0, 0, 4'b0000, 2'b00, 2'b00, 2'd3, 0));
    tbl.push_back(V(F_ALU, 4'hF, 4'h0, 2'b00, 0, 1, 4'b1000, 2'b00, 2'b00, 2'd0, 0));
    tbl.push_back(V(F_NONE,4'h0, 4'h0, 2'b00, 0, 0, 4'b0000, 2'b00, 2'b00, 2'd0, 0));
    // bring turn to 2, then slot 2 busy -> slot 3, turn wraps to 0
    tbl.push_back(V(F_ALU, 4'hF, 4'h0, 2'b00, 0, 1, 4'b0001, 2'b00, 2'b00, 2'd1, 0)); // 8
    tbl.push_back(V(F_ALU, 4'hF, 4'h0, 2'b00, 0, 0, 4'b0000, 2'b00, 2'b00, 2'd1, 0));
    tbl.push_back(V(F_ALU, 4'hF, 4'h0, 2'b00, 0, 1, 4'b0010, 2'b00, 2'b00, 2'd2, 0));
    tbl.push_back(V(F_NONE,4'h0, 4'h0, 2'b00, 0, 0, 4'b0000, 2'b00, 2'b00, 2'd2, 0));
    tbl.push_back(V(F_ALU, 4'hF, 4'h4, 2'b00, 0, 1, 4'b1000, 2'b00, 2'b00, 2'd0, 0));
    tbl.push_back(V(F_NONE,4'h0, 4'h0, 2'b00, 0, 0, 4'b0000, 2'b00, 2'b00, 2'd0, 0));
    // compat restricts; only candidate busy -> held, turn holds
    tbl.push_back(V(F_ALU, 4'h4, 4'h0, 2'b00, 0, 1, 4'b0100, 2'b00, 2'b00, 2'd3, 0)); // 14
    tbl.push_back(V(F_NONE,4'h0, 4'h0, 2'b00, 0, 0, 4'b0000, 2'b00, 2'b00, 2'd3, 0));
    tbl.push_back(V(F_ALU, 4'h1, 4'h1, 2'b00, 0, 0, 4'b0000, 2'b00, 2'b00, 2'd3, 0));
    tbl.push_back(V(F_ALU, 4'h1, 4'h0, 2'b00, 0, 1, 4'b0001, 2'b00, 2'b00, 2'd1, 0));
    tbl.push_back(V(F_NONE,4'h0, 4'h0, 2'b00, 0, 0, 4'b0000, 2'b00, 2'b00, 2'd1, 0));
    // three loads, two slots; ld_end[0] frees slot 0 for the third
    tbl.push_back(V(F_LD,  4'h0, 4'h0, 2'b00, 0, 1, 4'b0000, 2'b01, 2'b00, 2'd1, 0)); // 19
    tbl.push_back(V(F_LD,  4'h0, 4'h0, 2'b00, 0, 0, 4'b0000, 2'b00, 2'b01, 2'd1, 0));
    tbl.push_back(V(F_LD,  4'h0, 4'h0, 2'b00, 0, 1, 4'b0000, 2'b10, 2'b01, 2'd1, 0));
    tbl.push_back(V(F_LD,  4'h0, 4'h0, 2'b00, 0, 0, 4'b0000, 2'b00, 2'b11, 2'd1, 0));
    tbl.push_back(V(F_LD,  4'h0, 4'h0, 2'b00, 0, 0, 4'b0000, 2'b00, 2'b11, 2'd1, 0));
    tbl.push_back(V(F_LD,  4'h0, 4'h0, 2'b00, 0, 0, 4'b0000, 2'b00, 2'b11, 2'd1, 0));
    tbl.push_back(V(F_LD,  4'h0, 4'h0, 2'b01, 0, 0, 4'b0000, 2'b00, 2'b10, 2'd1, 0));
    tbl.push_back(V(F_LD,  4'h0, 4'h0, 2'b00, 0, 1, 4'b0000, 2'b01, 2'b10, 2'd1, 0));
    tbl.push_back(V(F_NONE,4'h0, 4'h0, 2'b00, 0, 0, 4'b0000, 2'b00, 2'b11, 2'd1, 0));
    tbl.push_back(V(F_NONE,4'h0, 4'h0, 2'b11, 0, 0, 4'b0000, 2'b00, 2'b00, 2'd1, 0));
    // load start and end in the same cycle: start wins
    tbl.push_back(V(F_LD,  4'h0, 4'h0, 2'b00, 0, 1, 4'b0000, 2'b01, 2'b00, 2'd1, 0)); // 29
    tbl.push_back(V(F_NONE,4'h0, 4'h0, 2'b01, 0, 0, 4'b0000, 2'b00, 2'b01, 2'd1, 0));
    tbl.push_back(V(F_NONE,4'h0, 4'h0, 2'b01, 0, 0, 4'b0000, 2'b00, 2'b00, 2'd1, 0));
    // store in slot 1 blocks the next store until slot_active[1] falls
    tbl.push_back(V(F_ST,  4'hF, 4'h0, 2'b00, 0, 1, 4'b0010, 2'b00, 2'b00, 2'd2, 0)); // 32
    tbl.push_back(V(F_ST,  4'hF, 4'h2, 2'b00, 0, 0, 4'b0000, 2'b00, 2'b00, 2'd2, 0));
    tbl.push_back(V(F_ST,  4'hF, 4'h2, 2'b00, 0, 0, 4'b0000, 2'b00, 2'b00, 2'd2, 0));
    tbl.push_back(V(F_ST,  4'hF, 4'h2, 2'b00, 0, 0, 4'b0000, 2'b00, 2'b00, 2'd2, 0));
    tbl.push_back(V(F_ST,  4'hF, 4'h0, 2'b00, 0, 0, 4'b0000, 2'b00, 2'b00, 2'd2, 0));
    tbl.push_back(V(F_ST,  4'hF, 4'h0, 2'b00, 0, 1, 4'b0100, 2'b00, 2'b00, 2'd3, 0));
    tbl.push_back(V(F_ST,  4'hF, 4'h0, 2'b00, 0, 0, 4'b0000, 2'b00, 2'b00, 2'd3, 0));
    // vcfg_done with an ALU grant: one ack pulse
    tbl.push_back(V(F_ALU, 4'hF, 4'h0, 2'b00, 1, 1, 4'b1000, 2'b00, 2'b00, 2'd0, 0)); // 39
    tbl.push_back(V(F_ALU, 4'hF, 4'h0, 2'b00, 0, 0, 4'b0000, 2'b00, 2'b00, 2'd0, 0));
    // stall suppresses the grant
    tbl.push_back(V(F_STL, 4'hF, 4'h0, 2'b00, 0, 0, 4'b0000, 2'b00, 2'b00, 2'd0, 0)); // 41
    tbl.push_back(V(F_ALU, 4'hF, 4'h0, 2'b00, 0, 1, 4'b0001, 2'b00, 2'b00, 2'd1, 0));
    tbl.push_back(V(F_NONE,4'h0, 4'h0, 2'b00, 0, 0, 4'b0000, 2'b00, 2'b00, 2'd1, 0));

    // reset state
    repeat (3) tick();
    chk("rst.ack", 32'(bus.ack), 32'h0);
    chk("rst.si", 32'(bus.slot_init), 32'h0);
    chk("rst.turn", 32'(bus.turn), 32'h0);
    chk("rst.fenced", 32'(bus.fenced), 32'h0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].flags, tbl[i].compat, tbl[i].act, tbl[i].lend, tbl[i].vd);
      tick();
      chk($sformatf("v%0d.ack", i), 32'(bus.ack), ackv(tbl[i].e_ack));
      chk($sformatf("v%0d.si", i), 32'(bus.slot_init), 32'(tbl[i].e_si));
      chk($sformatf("v%0d.li", i), 32'(bus.ld_slot_init), 32'(tbl[i].e_li));
      chk($sformatf("v%0d.lv", i), 32'(bus.ld_slot_valid), 32'(tbl[i].e_lv));
      chk($sformatf("v%0d.turn", i), 32'(bus.turn), 32'(tbl[i].e_turn));
      chk($sformatf("v%0d.fen", i), 32'(bus.fenced), 32'(tbl[i].e_fen));
    end

    // widen while slot 1 active: drain, then issue (turn 1 -> slot 1), then hold
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); drive(6'b100001, 4'hF, 4'h2, 2'b00, 1'b0); tick();
      chk($sformatf("drain%0d.fen", c), 32'(bus.fenced), 32'd1);
      chk($sformatf("drain%0d.ack", c), 32'(bus.ack), 32'h0);
    end
    @(negedge clk); drive(6'b100001, 4'hF, 4'h0, 2'b00, 1'b0); tick();
    chk("drain_exit.fen", 32'(bus.fenced), 32'd0);
    chk("drain_exit.ack", 32'(bus.ack), 32'h0);
    tick();
    chk("widen.ack", 32'(bus.ack), 32'h1FF);
    chk("widen.si", 32'(bus.slot_init), 32'b0010);
    tick();
    chk("widen.hold_fen", 32'(bus.fenced), 32'd1);
    // counter runs FENCE_MIN..0: FENCE_MIN+1 fenced cycles, next op gets slot 2
    hold_run("hold", 0, 0, FMIN + 1, 4'b0100);

    // serial again from idle (turn 3 -> slot 3), three stalled cycles in HOLD
    @(negedge clk); drive(6'b100001, 4'hF, 4'h0, 2'b00, 1'b0); tick();
    chk("widen2.ack", 32'(bus.ack), 32'h1FF);
    chk("widen2.si", 32'(bus.slot_init), 32'b1000);
    tick();
    chk("widen2.hold_fen", 32'(bus.fenced), 32'd1);
    hold_run("hold_stall", 1, 3, FMIN + 1 + 3, 4'b0001);

    // vcfg: no slot grant, ack follows vcfg_done, then fence
    @(negedge clk); drive(6'b100011, 4'h0, 4'h0, 2'b00, 1'b0); tick();
    chk("vcfg.wait_ack", 32'(bus.ack), 32'h0);
    chk("vcfg.wait_fen", 32'(bus.fenced), 32'd0);
    tick();
    chk("vcfg.wait_ack2", 32'(bus.ack), 32'h0);
    @(negedge clk); bus.vcfg_done = 1'b1; tick();
    chk("vcfg.ack", 32'(bus.ack), 32'h1FF);
    chk("vcfg.si", 32'(bus.slot_init), 32'h0);
    @(negedge clk); bus.vcfg_done = 1'b0; tick();
    chk("vcfg.hold_fen", 32'(bus.fenced), 32'd1);
    @(negedge clk); drive(F_NONE, 4'h0, 4'h0, 2'b00, 1'b0);
    done = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      tick();
      if (!bus.fenced) done = 1'b1;
    end
    chk("vcfg.hold_exit", 32'(done), 32'd1);

    // serial load enters HOLD with a load slot valid; reset clears everything
    @(negedge clk); drive(6'b101001, 4'h0, 4'h0, 2'b00, 1'b0); tick();
    chk("sld.ack", 32'(bus.ack), 32'h1FF);
    chk("sld.li", 32'(bus.ld_slot_init), 32'b01);
    tick();
    chk("sld.fen", 32'(bus.fenced), 32'd1);
    chk("sld.lv", 32'(bus.ld_slot_valid), 32'b01);
    chk("sld.turn", 32'(bus.turn), 32'd1);
    @(negedge clk); rst = 1'b1; drive(F_NONE, 4'h0, 4'h0, 2'b00, 1'b0); tick();
    chk("mrst.ack", 32'(bus.ack), 32'h0);
    chk("mrst.si", 32'(bus.slot_init), 32'h0);
    chk("mrst.li", 32'(bus.ld_slot_init), 32'h0);
    chk("mrst.lv", 32'(bus.ld_slot_valid), 32'h0);
    chk("mrst.turn", 32'(bus.turn), 32'h0);
    chk("mrst.fen", 32'(bus.fenced), 32'h0);
    @(negedge clk); rst = 1'b0; drive(F_ALU, 4'hF, 4'h0, 2'b00, 1'b0); tick();
    chk("post_rst.ack", 32'(bus.ack), 32'h1FF);
    chk("post_rst.si", 32'(bus.slot_init), 32'b0001);
    @(negedge clk); drive(F_NONE, 4'h0, 4'h0, 2'b00, 1'b0); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
